// File: rtl/sll_seq.sv
// Sequential 32-bit logical left shifter: one log-shifter stage (16,8,4,2,1) per
// clock under a start/done handshake, result held in out until the next completion.
module sll_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] inA,
  input  logic [4:0]  inB,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [31:0] out_q, out_d;
  logic [4:0]  amt_q, amt_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] stage_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= 32'h0;
      out_q   <= 32'h0;
      amt_q   <= 5'h0;
      k_q     <= 3'h0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      out_q   <= out_d;
      amt_q   <= amt_d;
      k_q     <= k_d;
    end
  end

  // One stage of the log shifter, selected by the current stage index.
  always_comb begin
    stage_val = data_q;
    case (k_q)
      3'd4: if (amt_q[4]) stage_val = data_q << 16;
      3'd3: if (amt_q[3]) stage_val = data_q << 8;
      3'd2: if (amt_q[2]) stage_val = data_q << 4;
      3'd1: if (amt_q[1]) stage_val = data_q << 2;
      3'd0: if (amt_q[0]) stage_val = data_q << 1;
      default: stage_val = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    out_d   = out_q;
    amt_d   = amt_q;
    k_d     = k_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          data_d  = inA;
          amt_d   = inB;
          k_d     = 3'd4;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        data_d = stage_val;
        if (k_q == 3'd0) begin
          out_d   = stage_val;
          state_d = DONE;
        end else begin
          k_d = k_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
    out  = out_q;
  end

endmodule

// File: tb/tb_sll_seq.sv
// Directed bench for sll_seq: latency/handshake checks, ignored start, back-to-back
// issue, mid-operation reset and a randomized run against inA << inB.
module tb_sll_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] inA;
  logic [4:0]  inB;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int start_cnt = 0;

  sll_seq dut (
    .clk(clk), .rst(rst), .start(start), .inA(inA), .inB(inB),
    .busy(busy), .done(done), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE and check the full 5-busy / 1-done timeline.
  task automatic do_op(input logic [31:0] a, input logic [4:0] b,
                       input logic [31:0] exp, input string tag);
    int nbusy;
    @(negedge clk);
    start = 1'b1; inA = a; inB = b;
    @(posedge clk); #1;
    start = 1'b0; inA = $urandom; inB = 5'($urandom);
    start_cnt++;
    nbusy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy && !done) nbusy++;
    end
    chk({tag, "_busy5"}, 32'(nbusy), 32'd5);
    @(negedge clk);
    chk({tag, "_done"}, {30'h0, busy, done}, 32'h1);
    chk({tag, "_out"}, out, exp);
    @(negedge clk);
    chk({tag, "_idle"}, {30'h0, busy, done}, 32'h0);
  endtask

  logic [31:0] va [8];
  logic [4:0]  vb [8];
  logic [31:0] ve [8];

  initial begin
    int dn;
    logic [31:0] seen;
    logic        held;
    logic [31:0] ra;
    logic [4:0]  rb;

    va[0] = 32'h0000_0001; vb[0] = 5'd31; ve[0] = 32'h8000_0000;
    va[1] = 32'hDEAD_BEEF; vb[1] = 5'd0;  ve[1] = 32'hDEAD_BEEF;
    va[2] = 32'hFFFF_FFFF; vb[2] = 5'd16; ve[2] = 32'hFFFF_0000;
    va[3] = 32'h1234_5678; vb[3] = 5'd4;  ve[3] = 32'h2345_6780;
    va[4] = 32'h8000_0001; vb[4] = 5'd1;  ve[4] = 32'h0000_0002;
    va[5] = 32'hAAAA_AAAA; vb[5] = 5'd31; ve[5] = 32'h0000_0000;
    va[6] = 32'hF0F0_F0F0; vb[6] = 5'd5;  ve[6] = 32'h1E1E_1E00;
    va[7] = 32'h0000_0003; vb[7] = 5'd30; ve[7] = 32'hC000_0000;

    rst = 1'b1; start = 1'b0; inA = 32'h0; inB = 5'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_flags", {30'h0, busy, done}, 32'h0);
    chk("reset_out", out, 32'h0);

    for (int i = 0; i < 8; i++) do_op(va[i], vb[i], ve[i], $sformatf("vec%0d", i));

    // start pulsed during the 3rd SHIFT cycle must be ignored
    @(negedge clk);
    start = 1'b1; inA = 32'h0000_00FF; inB = 5'd8;
    @(posedge clk); #1 start = 1'b0;
    start_cnt++;
    @(posedge clk); @(posedge clk); #1;
    start = 1'b1; inA = 32'h0; inB = 5'd1;
    @(posedge clk); #1 start = 1'b0;
    dn = 0; seen = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin dn++; seen = out; end
    end
    chk("ign_dones", 32'(dn), 32'd1);
    chk("ign_out", seen, 32'h0000_FF00);
    chk("ign_hold", out, 32'h0000_FF00);

    // back-to-back issue with start held high
    @(negedge clk);
    start = 1'b1; inA = 32'h1; inB = 5'd1;
    repeat (5) @(negedge clk);
    @(negedge clk);
    chk("b2b_done1", {30'h0, busy, done}, 32'h1);
    chk("b2b_out1", out, 32'h2);
    inA = 32'h3; inB = 5'd2;
    @(posedge clk); #1 start = 1'b0;
    start_cnt += 2;
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out !== 32'h2 || !busy) held = 1'b0;
    end
    chk("b2b_hold", {31'h0, held}, 32'h1);
    @(negedge clk);
    chk("b2b_done2", {30'h0, busy, done}, 32'h1);
    chk("b2b_out2", out, 32'hC);

    // reset in the 2nd SHIFT cycle aborts the op
    @(negedge clk);
    start = 1'b1; inA = 32'hFFFF_FFFF; inB = 5'd1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_flags", {30'h0, busy, done}, 32'h0);
    chk("rst_out", out, 32'h0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("rst_quiet", 32'(dn), 32'd0);
    do_op(32'h0000_00F0, 5'd4, 32'h0000_0F00, "post_rst");

    // randomized run
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = $urandom;
      rb = 5'($urandom_range(0, 31));
      do_op(ra, rb, ra << rb, $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'(start_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
